cipher_lane_pipe: RTL and testbench

Parametrised successor to the fixed 8-round encryption lane. It provides a configurable round count and width, per-block encrypt/decrypt mode, and runtime-loadable round keys. Each stage has its own valid/ready handshake, so bubbles collapse instead of freezing the whole pipeline. It sits between the distributor and the combiner, one instance per lane, and carries a sequence ID alongside each block.

---
 rtl/cipher_lane_pipe.sv | 160 ++++++++++++++++
 tb/tb_cipher_lane_pipe.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_lane_pipe.sv
// Keyed ARX cipher lane: NUM_ROUNDS stages with per-stage valid/ready, one round per stage.
// Define CIPHER_LANE_STATS_EN to add the blk_in_cnt/stall_cnt counter ports.
module cipher_lane_pipe #(
  parameter int BLOCK_WIDTH  = 32,
  parameter int SEQ_ID_WIDTH = 8,
  parameter int NUM_ROUNDS   = 8,
  parameter int ROT          = 3,
  parameter int KEY_IDX_W    = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BLOCK_WIDTH-1:0]  data_in,
  input  logic [SEQ_ID_WIDTH-1:0] seq_id_in,
  input  logic                    mode_in,
  input  logic                    data_in_valid,
  output logic                    data_in_ready,
  output logic [BLOCK_WIDTH-1:0]  data_out,
  output logic [SEQ_ID_WIDTH-1:0] seq_id_out,
  output logic                    mode_out,
  output logic                    data_out_valid,
  input  logic                    data_out_ready,
  input  logic                    key_wr_en,
  input  logic [KEY_IDX_W-1:0]    key_wr_idx,
  input  logic [BLOCK_WIDTH-1:0]  key_wr_data,
  output logic                    key_wr_ready,
  output logic                    busy
`ifdef CIPHER_LANE_STATS_EN
  ,
  output logic [31:0]             blk_in_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  function automatic logic [BLOCK_WIDTH-1:0] enc_round(input logic [BLOCK_WIDTH-1:0] x,
                                                       input logic [BLOCK_WIDTH-1:0] k);
    logic [BLOCK_WIDTH-1:0] t;
    t = (x ^ k) + k;
    return (t << ROT) | (t >> (BLOCK_WIDTH - ROT));
  endfunction

  function automatic logic [BLOCK_WIDTH-1:0] dec_round(input logic [BLOCK_WIDTH-1:0] y,
                                                       input logic [BLOCK_WIDTH-1:0] k);
    logic [BLOCK_WIDTH-1:0] t;
    t = (y >> ROT) | (y << (BLOCK_WIDTH - ROT));
    return (t - k) ^ k;
  endfunction

  logic [BLOCK_WIDTH-1:0]  data_q [NUM_ROUNDS];
  logic [BLOCK_WIDTH-1:0]  data_d [NUM_ROUNDS];
  logic [SEQ_ID_WIDTH-1:0] seq_q  [NUM_ROUNDS];
  logic [SEQ_ID_WIDTH-1:0] seq_d  [NUM_ROUNDS];
  logic [BLOCK_WIDTH-1:0]  key_q  [NUM_ROUNDS];
  logic [BLOCK_WIDTH-1:0]  key_d  [NUM_ROUNDS];
  logic [NUM_ROUNDS-1:0]   vld_q, vld_d, mode_q, mode_d;
  logic [NUM_ROUNDS-1:0]   rdy;

  logic [BLOCK_WIDTH-1:0]  in_dat  [NUM_ROUNDS];
  logic [SEQ_ID_WIDTH-1:0] in_seq  [NUM_ROUNDS];
  logic [NUM_ROUNDS-1:0]   in_mode, in_vld;

  // A stage is blocked only if it and every stage after it are full and the output is stalled.
  always_comb begin
    logic full;
    rdy  = '0;
    full = !data_out_ready;
    for (int i = NUM_ROUNDS - 1; i >= 0; i--) begin
      full   = full & vld_q[i];
      rdy[i] = !full;
    end
  end

  always_comb begin
    in_dat[0]  = data_in;
    in_seq[0]  = seq_id_in;
    in_mode[0] = mode_in;
    in_vld[0]  = data_in_valid;
    for (int i = 1; i < NUM_ROUNDS; i++) begin
      in_dat[i]  = data_q[i-1];
      in_seq[i]  = seq_q[i-1];
      in_mode[i] = mode_q[i-1];
      in_vld[i]  = vld_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      data_d[i] = data_q[i];
      seq_d[i]  = seq_q[i];
      mode_d[i] = mode_q[i];
      vld_d[i]  = vld_q[i];
      if (rdy[i]) begin
        vld_d[i] = in_vld[i];
        if (in_vld[i]) begin
          // Decrypt walks the key schedule backwards so it undoes encrypt round by round.
          data_d[i] = in_mode[i] ? dec_round(in_dat[i], key_q[NUM_ROUNDS-1-i])
                                 : enc_round(in_dat[i], key_q[i]);
          seq_d[i]  = in_seq[i];
          mode_d[i] = in_mode[i];
        end
      end
    end
  end

  assign busy         = |vld_q;
  assign key_wr_ready = !busy && !data_in_valid;

  // Out-of-range indices match no slot, so the write is handshaken but dropped.
  always_comb begin
    for (int k = 0; k < NUM_ROUNDS; k++) begin
      key_d[k] = key_q[k];
      if (key_wr_en && key_wr_ready && (key_wr_idx == KEY_IDX_W'(k))) begin
        key_d[k] = key_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      mode_q <= '0;
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        data_q[i] <= '0;
        seq_q[i]  <= '0;
        key_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      mode_q <= mode_d;
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        data_q[i] <= data_d[i];
        seq_q[i]  <= seq_d[i];
        key_q[i]  <= key_d[i];
      end
    end
  end

  assign data_in_ready  = rdy[0];
  assign data_out       = data_q[NUM_ROUNDS-1];
  assign seq_id_out     = seq_q[NUM_ROUNDS-1];
  assign mode_out       = mode_q[NUM_ROUNDS-1];
  assign data_out_valid = vld_q[NUM_ROUNDS-1];

`ifdef CIPHER_LANE_STATS_EN
  logic [31:0] blk_in_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_in_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (data_in_valid && rdy[0]) blk_in_cnt_q <= blk_in_cnt_q + 32'd1;
      if (data_out_valid && !data_out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign blk_in_cnt = blk_in_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cipher_lane_pipe.sv
// Bench for cipher_lane_pipe: vector table, directed corner sequences and a randomized
// phase, all checked against a transaction-level queue model with its own key copy.
module tb_cipher_lane_pipe;
  localparam int W  = 32;
  localparam int S  = 8;
  localparam int N  = 8;
  localparam int KW = 4;  // wide enough to present index 9 to an 8-round lane

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [S-1:0]  seq_id_in = '0;
  logic          mode_in = 1'b0;
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [W-1:0]  data_out;
  logic [S-1:0]  seq_id_out;
  logic          mode_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b1;
  logic          key_wr_en = 1'b0;
  logic [KW-1:0] key_wr_idx = '0;
  logic [W-1:0]  key_wr_data = '0;
  logic          key_wr_ready;
  logic          busy;

  always #5 clk = ~clk;

  cipher_lane_pipe #(
    .BLOCK_WIDTH(W), .SEQ_ID_WIDTH(S), .NUM_ROUNDS(N), .ROT(3), .KEY_IDX_W(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .seq_id_in(seq_id_in), .mode_in(mode_in),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .seq_id_out(seq_id_out), .mode_out(mode_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .key_wr_ready(key_wr_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: keys as a plain array, whole-block cipher as a loop of rounds.
  logic [W-1:0] mkey [N];

  function automatic logic [W-1:0] ref_cipher(input logic [W-1:0] x_in, input logic m);
    logic [W-1:0] x, t, k;
    x = x_in;
    for (int r = 0; r < N; r++) begin
      k = m ? mkey[N-1-r] : mkey[r];
      if (!m) begin
        t = (x ^ k) + k;
        x = {t[W-4:0], t[W-1:W-3]};
      end else begin
        t = {x[2:0], x[W-1:3]};
        x = (t - k) ^ k;
      end
    end
    return x;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] s;
    logic         m;
  } blk_t;

  blk_t expq[$];
  int   out_cnt = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_d;
  logic [S-1:0]  prev_s;
  logic          prev_m;

  // Monitor: samples mid-cycle, where handshakes about to complete are visible.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
      for (int i = 0; i < N; i++) mkey[i] = '0;
    end else begin
      int   occ;
      logic exp_ir, exp_kr;
      blk_t e;
      occ    = expq.size();
      exp_ir = !(occ == N && !data_out_ready);
      exp_kr = (occ == 0) && !data_in_valid;
      check("in_ready", data_in_ready, exp_ir);
      check("busy", busy, occ != 0);
      check("key_wr_ready", key_wr_ready, exp_kr);
      if (prev_stall) begin
        check("stall_valid", data_out_valid, 1'b1);
        check("stall_data", data_out, prev_d);
        check("stall_seq", seq_id_out, prev_s);
        check("stall_mode", mode_out, prev_m);
      end
      if (data_out_valid && data_out_ready) begin
        out_cnt++;
        if (occ == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = expq.pop_front();
          check("out_data", data_out, e.d);
          check("out_seq", seq_id_out, e.s);
          check("out_mode", mode_out, e.m);
        end
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev_d = data_out;
      prev_s = seq_id_out;
      prev_m = mode_out;
      if (data_in_valid && exp_ir) begin
        e.d = ref_cipher(data_in, mode_in);
        e.s = seq_id_in;
        e.m = mode_in;
        expq.push_back(e);
      end
      if (key_wr_en && exp_kr && key_wr_idx < N) mkey[key_wr_idx[2:0]] = key_wr_data;
    end
  end

  task automatic send_one(input logic [W-1:0] d, input logic [S-1:0] s, input logic m,
                          output int lat);
    @(posedge clk); #1;
    data_in = d; seq_id_in = s; mode_in = m; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    lat = 1;
    while (!data_out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic write_key(input logic [KW-1:0] idx, input logic [W-1:0] v,
                           input logic exp_rdy, input string nm);
    @(posedge clk); #1;
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_data = v;
    #1 check(nm, key_wr_ready, exp_rdy);
    @(posedge clk); #1;
    key_wr_en = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && busy; i++) begin
      @(posedge clk); #1;
    end
    check(nm, busy, 1'b0);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic [S-1:0] s;
    logic         m;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [5];
    logic [W-1:0] keys [N];
    logic [W-1:0] c;
    int           lat;
    int           base;
    logic         saw_full;
    logic [S-1:0] seq;

    // Zero keys: every round is a rotl by 3, so 8 rounds rotate by 24.
    vt[0] = '{32'h0000_0001, 8'h05, 1'b0, 32'h0100_0000};
    vt[1] = '{32'h0100_0000, 8'h06, 1'b1, 32'h0000_0001};
    vt[2] = '{32'h8000_0000, 8'h07, 1'b0, 32'h0080_0000};
    vt[3] = '{32'hDEAD_BEEF, 8'h08, 1'b0, 32'hEFDE_ADBE};
    vt[4] = '{32'h1234_5678, 8'h09, 1'b1, 32'h3456_7812};
    keys = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0,
             32'hFEDCBA98, 32'h76543210, 32'hAAAAAAAA, 32'h55555555};

    #1;
    check("rst_out_valid", data_out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", data_in_ready, 1'b1);
    check("rst_key_wr_ready", key_wr_ready, 1'b1);
    check("rst_data_out", data_out, 32'h0);
    #20 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      send_one(vt[i].d, vt[i].s, vt[i].m, lat);
      check("vec_latency", lat, 8);
      check("vec_data", data_out, vt[i].exp);
      check("vec_seq", seq_id_out, vt[i].s);
      check("vec_mode", mode_out, vt[i].m);
    end
    drain("drain_vec");

    for (int i = 0; i < N; i++) write_key(KW'(i), keys[i], 1'b1, "key_load_ready");
    send_one(32'h1234_5678, 8'h20, 1'b0, lat);
    c = data_out;
    check("key_enc_model", c, ref_cipher(32'h1234_5678, 1'b0));
    send_one(c, 8'h21, 1'b1, lat);
    check("key_roundtrip", data_out, 32'h1234_5678);
    drain("drain_keys");

    // Back-to-back stream with a 5-cycle output stall once the pipe is full.
    base = out_cnt;
    saw_full = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        logic acc;
        for (int b = 0; b < 12; b++) begin
          data_in_valid = 1'b1; data_in = $urandom; seq_id_in = S'(64 + b); mode_in = b[0];
          acc = 1'b0;
          for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk); acc = data_in_ready;
            @(posedge clk); #1;
          end
        end
        data_in_valid = 1'b0;
      end
      begin
        int t;
        t = 0;
        while (!data_out_valid && t < 40) begin
          @(posedge clk); #1;
          t++;
        end
        data_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          if (!data_in_ready) saw_full = 1'b1;
          @(posedge clk); #1;
        end
        data_out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    check("stream_count", out_cnt - base, 12);
    check("stream_full_seen", saw_full, 1'b1);

    // Key writes refused while busy or while data is offered; out-of-range index is dropped.
    @(posedge clk); #1;
    data_in = 32'hA5A5_0001; seq_id_in = 8'h30; mode_in = 1'b0; data_in_valid = 1'b1;
    @(posedge clk); #1;
    data_in_valid = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = 32'hFFFF_FFFF;
    #1 check("kwr_busy_ready", key_wr_ready, 1'b0);
    @(posedge clk); #1;
    key_wr_en = 1'b0;
    drain("drain_kwr1");
    @(posedge clk); #1;
    data_in = 32'hA5A5_0002; seq_id_in = 8'h31; data_in_valid = 1'b1;
    key_wr_en = 1'b1; key_wr_idx = 4'd1; key_wr_data = 32'hFFFF_FFFF;
    #1 check("kwr_valid_ready", key_wr_ready, 1'b0);
    @(posedge clk); #1;
    data_in_valid = 1'b0; key_wr_en = 1'b0;
    drain("drain_kwr2");
    write_key(4'd9, 32'hFFFF_FFFF, 1'b1, "kwr_idx9_ready");
    send_one(32'h1234_5678, 8'h32, 1'b0, lat);
    check("kwr_keys_unchanged", data_out, c);
    drain("drain_kwr3");

    // Randomized traffic, including idle windows where key writes can land.
    seq = 8'h80;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      data_in_valid  = ((cyc % 50) < 35) && ($urandom_range(0, 3) != 0);
      data_in        = $urandom;
      mode_in        = 1'($urandom_range(0, 1));
      seq_id_in      = seq;
      seq            = seq + 8'd1;
      data_out_ready = ($urandom_range(0, 3) != 0);
      key_wr_en      = ($urandom_range(0, 3) == 0);
      key_wr_idx     = KW'($urandom_range(0, 15));
      key_wr_data    = $urandom;
    end
    @(posedge clk); #1;
    data_in_valid = 1'b0; key_wr_en = 1'b0; data_out_ready = 1'b1;
    drain("drain_random");
    check("random_queue_empty", expq.size(), 0);

    // Asynchronous reset with four blocks in flight.
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      data_in = $urandom; seq_id_in = S'(b); mode_in = 1'b0; data_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    for (int t = 0; t < 20 && !data_out_valid; t++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_valid", data_out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", data_out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data_out", data_out, 32'h0);
    check("midrst_seq_out", seq_id_out, 8'h0);
    check("midrst_in_ready", data_in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_one(32'h0000_0001, 8'h05, 1'b0, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_zero_keys", data_out, 32'h0100_0000);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
